hazard_forward_unit: RTL

Execute-stage hazard controller that generates the forward-select codes consumed by the two ALU operand forward muxes, and the load-use stall/bubble controls for fetch, decode and execute. It keeps its own shadow copy of the destination-register fields of the EX/MEM and MEM/WB stages. It compares those fields against the source registers of the instruction in execute and of the instruction in decode. It also counts stall cycles for performance monitoring.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/forward_compare.sv | 30 +++
 rtl/hazard_forward_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: operand forward-select codes, hazard FSM states
// and the register address width used by the hazard/forwarding logic.
package riscv_pkg;

    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

    typedef enum logic {
        RUN,
        STALL
    } hazard_state_t;

endpackage

// File: rtl/forward_compare.sv
// Priority compare for one ALU operand: picks EX/MEM, then MEM/WB, then the
// register file. x0 is never forwarded and a load still in EX/MEM is skipped.
module forward_compare
    import riscv_pkg::*;
(
    input  logic [REG_ADDR_WIDTH-1:0] sourceReg,
    input  logic [REG_ADDR_WIDTH-1:0] memRd,
    input  logic                      memRegWrite,
    input  logic                      memMemRead,
    input  logic [REG_ADDR_WIDTH-1:0] wbRd,
    input  logic                      wbRegWrite,
    output logic [1:0]                forwardSelect
);

    logic memHit;
    logic wbHit;

    assign memHit = memRegWrite && (memRd != '0) && (memRd == sourceReg) && !memMemRead;
    assign wbHit  = wbRegWrite && (wbRd != '0) && (wbRd == sourceReg);

    always_comb begin
        forwardSelect = FWD_REGFILE;
        if (memHit) begin
            forwardSelect = FWD_EXMEM;
        end else if (wbHit) begin
            forwardSelect = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Execute-stage hazard controller: ALU operand forward selects, load-use
// stall/bubble generation and a saturating stall-cycle counter.
module hazard_forward_unit
    import riscv_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int COUNT_WIDTH       = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] decodeRs1,
    input  logic [REG_ADDR_WIDTH-1:0] decodeRs2,
    input  logic                      decodeUsesRs1,
    input  logic                      decodeUsesRs2,
    input  logic [REG_ADDR_WIDTH-1:0] executeRs1,
    input  logic [REG_ADDR_WIDTH-1:0] executeRs2,
    input  logic [REG_ADDR_WIDTH-1:0] executeRd,
    input  logic                      executeRegWrite,
    input  logic                      executeMemRead,
    input  logic                      flush,
    output logic [1:0]                forwardSelect1,
    output logic [1:0]                forwardSelect2,
    output logic                      stallFetch,
    output logic                      stallDecode,
    output logic                      bubbleExecute,
    output logic [COUNT_WIDTH-1:0]    stallCount
);

    localparam logic [1:0] STALL_RELOAD = 2'(LOAD_STALL_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic [REG_ADDR_WIDTH-1:0] memRd;
    logic                      memRegWrite;
    logic                      memMemRead;
    logic [REG_ADDR_WIDTH-1:0] wbRd;
    logic                      wbRegWrite;

    hazard_state_t state;
    hazard_state_t stateNext;
    logic [1:0]    remaining;
    logic [1:0]    remainingNext;
    logic          stallActive;
    logic          bubbleActive;
    logic          loadUseHazard;

    // The shadow pipeline never stalls: EX, MEM and WB always advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            memRd       <= '0;
            memRegWrite <= 1'b0;
            memMemRead  <= 1'b0;
            wbRd        <= '0;
            wbRegWrite  <= 1'b0;
        end else begin
            memRd       <= executeRd;
            memRegWrite <= executeRegWrite;
            memMemRead  <= executeMemRead;
            wbRd        <= memRd;
            wbRegWrite  <= memRegWrite;
        end
    end

    forward_compare u_forward_rs1 (
        .sourceReg     (executeRs1),
        .memRd         (memRd),
        .memRegWrite   (memRegWrite),
        .memMemRead    (memMemRead),
        .wbRd          (wbRd),
        .wbRegWrite    (wbRegWrite),
        .forwardSelect (forwardSelect1)
    );

    forward_compare u_forward_rs2 (
        .sourceReg     (executeRs2),
        .memRd         (memRd),
        .memRegWrite   (memRegWrite),
        .memMemRead    (memMemRead),
        .wbRd          (wbRd),
        .wbRegWrite    (wbRegWrite),
        .forwardSelect (forwardSelect2)
    );

    assign loadUseHazard = executeMemRead && executeRegWrite && (executeRd != '0) &&
                           ((decodeUsesRs1 && (decodeRs1 == executeRd)) ||
                            (decodeUsesRs2 && (decodeRs2 == executeRd)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            remaining <= 2'd0;
        end else begin
            state     <= stateNext;
            remaining <= remainingNext;
        end
    end

    // A flush squashes the stalled instruction, so it also cancels any stall in progress.
    always_comb begin
        stateNext     = state;
        remainingNext = remaining;
        stallActive   = 1'b0;
        bubbleActive  = 1'b0;
        if (flush) begin
            stateNext     = RUN;
            remainingNext = 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (loadUseHazard) begin
                        stallActive  = 1'b1;
                        bubbleActive = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            stateNext     = STALL;
                            remainingNext = STALL_RELOAD;
                        end
                    end
                end
                STALL: begin
                    stallActive   = 1'b1;
                    bubbleActive  = 1'b1;
                    remainingNext = remaining - 2'd1;
                    if (remaining == 2'd1) begin
                        stateNext = RUN;
                    end
                end
                default: begin
                    stateNext     = RUN;
                    remainingNext = 2'd0;
                end
            endcase
        end
    end

    assign stallFetch    = stallActive;
    assign stallDecode   = stallActive;
    assign bubbleExecute = bubbleActive;

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount <= '0;
        end else if (stallDecode && (stallCount != '1)) begin
            stallCount <= stallCount + COUNT_ONE;
        end
    end

    // After a correct stall a load can never sit in EX/MEM while its consumer is in execute.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(memRegWrite && memMemRead && (memRd != '0) &&
                      ((memRd == executeRs1) || (memRd == executeRs2))));
        end
    end

endmodule
